mem_stage_mo: RTL and testbench

- Parametrised MEM pipeline stage. Successor to the single-entry MEM register.
- Holds up to DEPTH in-order instructions, so EX can issue several loads/stores before earlier data_sram responses return.
- Matches in-order data_ok responses to entries, sign/zero-extends load data, feeds WB with valid/allowin handshake, and exposes per-entry forwarding to ID.
- On flush, drops responses still in flight for flushed requests, using a discard counter.

---
 rtl/mem_pkg.sv | 9 +
 rtl/load_ext.sv | 32 +++
 rtl/mem_stage_mo.sv | 196 +++++++++++++++++++
 tb/tb_mem_stage_mo.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the MEM stage.
// These are the load-size encodings carried from EX in ex_ld_size.
package mem_pkg;

    localparam logic [1:0] LD_B = 2'b00;
    localparam logic [1:0] LD_H = 2'b01;
    localparam logic [1:0] LD_W = 2'b10;

endpackage

// File: rtl/load_ext.sv
// Selects the addressed byte or halfword from a 32-bit load response and
// sign- or zero-extends it. Size 2'b11 is handled the same as a word load.
module load_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_i)
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            2'd3:    byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            LD_B:    result_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            LD_H:    result_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_mo.sv
// Multi-outstanding MEM stage: an in-order FIFO of instructions waiting on
// data_sram responses, with bypass to WB, per-entry forwarding and flush discard.
module mem_stage_mo
    import mem_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int META_W = 128,
    parameter int RF_AW  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ex_valid,
    output logic                   mem_allowin,
    input  logic [31:0]            ex_pc,
    input  logic                   ex_rf_we,
    input  logic [RF_AW-1:0]       ex_rf_waddr,
    input  logic [31:0]            ex_alu_result,
    input  logic                   ex_ld,
    input  logic                   ex_req,
    input  logic [1:0]             ex_ld_size,
    input  logic                   ex_ld_unsigned,
    input  logic                   ex_excep,
    input  logic                   ex_ertn,
    input  logic [META_W-1:0]      ex_meta,
    input  logic                   data_sram_data_ok,
    input  logic [31:0]            data_sram_rdata,
    input  logic                   flush,
    input  logic                   wb_allowin,
    output logic                   mem_to_wb_valid,
    output logic [31:0]            wb_pc,
    output logic                   wb_rf_we,
    output logic [RF_AW-1:0]       wb_rf_waddr,
    output logic [31:0]            wb_rf_wdata,
    output logic                   wb_excep,
    output logic                   wb_ertn,
    output logic [META_W-1:0]      wb_meta,
    output logic [DEPTH-1:0]       fwd_valid,
    output logic [RF_AW*DEPTH-1:0] fwd_waddr,
    output logic [DEPTH-1:0]       fwd_ready,
    output logic [32*DEPTH-1:0]    fwd_wdata,
    output logic                   mem_excep_pending,
    output logic                   discard_busy
);

    localparam int PW  = $clog2(DEPTH);
    localparam int PTW = PW + 1;
    localparam int CW  = $clog2(2*DEPTH+2);

    logic [PTW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [DEPTH-1:0]  valid_q, rf_we_q, ld_q, req_q, uns_q, excep_q, ertn_q, resp_got_q;
    logic [31:0]       pc_q    [DEPTH];
    logic [31:0]       alu_q   [DEPTH];
    logic [31:0]       wdata_q [DEPTH];
    logic [RF_AW-1:0]  waddr_q [DEPTH];
    logic [1:0]        size_q  [DEPTH];
    logic [META_W-1:0] meta_q  [DEPTH];

    logic [PW-1:0] hidx, tidx, resp_idx;
    logic [CW-1:0] outstanding;
    logic          full, head_valid, waiting, discard_nz, take, bypass, enq, deq;
    logic [31:0]   ext_data;

    assign hidx       = head_q[PW-1:0];
    assign tidx       = tail_q[PW-1:0];
    assign head_valid = valid_q[hidx];
    assign full       = (head_q[PW] != tail_q[PW]) && (hidx == tidx);
    assign discard_nz = (discard_q != '0);

    // Walk entries oldest-first to find the one the next response belongs to.
    always_comb begin
        waiting     = 1'b0;
        resp_idx    = '0;
        outstanding = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_q[hidx + PW'(k)] && req_q[hidx + PW'(k)] && !resp_got_q[hidx + PW'(k)]) begin
                outstanding = outstanding + CW'(1);
                if (!waiting) begin
                    waiting  = 1'b1;
                    resp_idx = hidx + PW'(k);
                end
            end
        end
    end

    load_ext u_load_ext (
        .rdata_i    (data_sram_rdata),
        .addr_i     (alu_q[resp_idx][1:0]),
        .size_i     (size_q[resp_idx]),
        .unsigned_i (uns_q[resp_idx]),
        .result_o   (ext_data)
    );

    assign take            = data_sram_data_ok && !discard_nz && waiting;
    assign bypass          = take && (resp_idx == hidx);
    assign mem_to_wb_valid = head_valid && (resp_got_q[hidx] || bypass);
    assign deq             = mem_to_wb_valid && wb_allowin;
    assign mem_allowin     = !full || deq;
    assign enq             = ex_valid && mem_allowin && !flush;

    always_comb begin
        head_d    = head_q + PTW'(deq);
        tail_d    = tail_q + PTW'(enq);
        discard_d = discard_q;
        if (discard_nz && data_sram_data_ok) begin
            discard_d = discard_q - CW'(1);
        end
        // Everything still owed to flushed entries, plus the request EX just made.
        if (flush) begin
            head_d    = '0;
            tail_d    = '0;
            discard_d = discard_d + outstanding - CW'(take) + CW'(ex_valid && ex_req);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            discard_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            discard_q <= discard_d;
            if (flush) begin
                valid_q <= '0;
            end else begin
                if (take) begin
                    resp_got_q[resp_idx] <= 1'b1;
                    if (ld_q[resp_idx]) begin
                        wdata_q[resp_idx] <= ext_data;
                    end
                end
                if (deq) begin
                    valid_q[hidx] <= 1'b0;
                end
                // Placed last: a full FIFO reuses the slot the head vacates this cycle.
                if (enq) begin
                    valid_q[tidx]    <= 1'b1;
                    pc_q[tidx]       <= ex_pc;
                    rf_we_q[tidx]    <= ex_rf_we;
                    waddr_q[tidx]    <= ex_rf_waddr;
                    alu_q[tidx]      <= ex_alu_result;
                    wdata_q[tidx]    <= ex_alu_result;
                    ld_q[tidx]       <= ex_ld;
                    req_q[tidx]      <= ex_req;
                    resp_got_q[tidx] <= !ex_req;
                    size_q[tidx]     <= ex_ld_size;
                    uns_q[tidx]      <= ex_ld_unsigned;
                    excep_q[tidx]    <= ex_excep;
                    ertn_q[tidx]     <= ex_ertn;
                    meta_q[tidx]     <= ex_meta;
                end
            end
        end
    end

    always_comb begin
        wb_pc       = head_valid ? pc_q[hidx]    : '0;
        wb_rf_we    = head_valid && rf_we_q[hidx];
        wb_rf_waddr = head_valid ? waddr_q[hidx] : '0;
        wb_excep    = head_valid && excep_q[hidx];
        wb_ertn     = head_valid && ertn_q[hidx];
        wb_meta     = head_valid ? meta_q[hidx]  : '0;
        wb_rf_wdata = '0;
        if (head_valid) begin
            wb_rf_wdata = (bypass && ld_q[hidx]) ? ext_data : wdata_q[hidx];
        end
    end

    // Forwarding slot k is the k-th oldest entry; a load answered this cycle forwards live data.
    always_comb begin
        fwd_valid = '0;
        fwd_ready = '0;
        fwd_waddr = '0;
        fwd_wdata = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_q[hidx + PW'(k)]) begin
                fwd_valid[k] = rf_we_q[hidx + PW'(k)];
                fwd_waddr[k*RF_AW +: RF_AW] = waddr_q[hidx + PW'(k)];
                fwd_ready[k] = !ld_q[hidx + PW'(k)] || resp_got_q[hidx + PW'(k)]
                               || (take && (resp_idx == hidx + PW'(k)));
                fwd_wdata[k*32 +: 32] = (take && (resp_idx == hidx + PW'(k)) && ld_q[hidx + PW'(k)])
                                        ? ext_data : wdata_q[hidx + PW'(k)];
            end
        end
    end

    assign mem_excep_pending = |(valid_q & (excep_q | ertn_q));
    assign discard_busy      = discard_nz;

    a_no_stray_response: assert property (@(posedge clk) disable iff (reset)
        !(data_sram_data_ok && !discard_nz && !waiting));

endmodule

// File: tb/tb_mem_stage_mo.sv
// Directed bench for mem_stage_mo: expected WB transfers are queued at issue
// time and a separate monitor pops and compares each one WB accepts.
module tb_mem_stage_mo;
    import mem_pkg::*;

    localparam int DEPTH  = 2;
    localparam int META_W = 128;
    localparam int RF_AW  = 5;

    logic                   clk;
    logic                   reset;
    logic                   ex_valid;
    logic                   mem_allowin;
    logic [31:0]            ex_pc;
    logic                   ex_rf_we;
    logic [RF_AW-1:0]       ex_rf_waddr;
    logic [31:0]            ex_alu_result;
    logic                   ex_ld;
    logic                   ex_req;
    logic [1:0]             ex_ld_size;
    logic                   ex_ld_unsigned;
    logic                   ex_excep;
    logic                   ex_ertn;
    logic [META_W-1:0]      ex_meta;
    logic                   data_sram_data_ok;
    logic [31:0]            data_sram_rdata;
    logic                   flush;
    logic                   wb_allowin;
    logic                   mem_to_wb_valid;
    logic [31:0]            wb_pc;
    logic                   wb_rf_we;
    logic [RF_AW-1:0]       wb_rf_waddr;
    logic [31:0]            wb_rf_wdata;
    logic                   wb_excep;
    logic                   wb_ertn;
    logic [META_W-1:0]      wb_meta;
    logic [DEPTH-1:0]       fwd_valid;
    logic [RF_AW*DEPTH-1:0] fwd_waddr;
    logic [DEPTH-1:0]       fwd_ready;
    logic [32*DEPTH-1:0]    fwd_wdata;
    logic                   mem_excep_pending;
    logic                   discard_busy;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] wdata;
        logic        excep;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    mem_stage_mo #(.DEPTH(DEPTH), .META_W(META_W), .RF_AW(RF_AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .ex_valid          (ex_valid),
        .mem_allowin       (mem_allowin),
        .ex_pc             (ex_pc),
        .ex_rf_we          (ex_rf_we),
        .ex_rf_waddr       (ex_rf_waddr),
        .ex_alu_result     (ex_alu_result),
        .ex_ld             (ex_ld),
        .ex_req            (ex_req),
        .ex_ld_size        (ex_ld_size),
        .ex_ld_unsigned    (ex_ld_unsigned),
        .ex_excep          (ex_excep),
        .ex_ertn           (ex_ertn),
        .ex_meta           (ex_meta),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .flush             (flush),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .wb_pc             (wb_pc),
        .wb_rf_we          (wb_rf_we),
        .wb_rf_waddr       (wb_rf_waddr),
        .wb_rf_wdata       (wb_rf_wdata),
        .wb_excep          (wb_excep),
        .wb_ertn           (wb_ertn),
        .wb_meta           (wb_meta),
        .fwd_valid         (fwd_valid),
        .fwd_waddr         (fwd_waddr),
        .fwd_ready         (fwd_ready),
        .fwd_wdata         (fwd_wdata),
        .mem_excep_pending (mem_excep_pending),
        .discard_busy      (discard_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setEx(input logic [31:0] pc, input logic [31:0] alu, input logic ld,
                         input logic req, input logic [1:0] size, input logic uns, input logic excep);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_rf_we       = 1'b1;
        ex_rf_waddr    = pc[6:2];
        ex_alu_result  = alu;
        ex_ld          = ld;
        ex_req         = req;
        ex_ld_size     = size;
        ex_ld_unsigned = uns;
        ex_excep       = excep;
        ex_ertn        = 1'b0;
        ex_meta        = {4{pc}};
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] wdata, input logic excep);
        exp_t e;
        e.pc    = pc;
        e.wdata = wdata;
        e.excep = excep;
        expQ.push_back(e);
    endtask

    // One-cycle EX offer that the caller knows will be accepted.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] alu, input logic ld,
                                 input logic req, input logic [1:0] size, input logic uns,
                                 input logic excep, input logic push, input logic [31:0] expWdata);
        setEx(pc, alu, ld, req, size, uns, excep);
        if (push) pushExp(pc, expWdata, excep);
        step();
        ex_valid = 1'b0;
        ex_excep = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = d;
        step();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic respondDropped(input logic [31:0] d, input logic expBusyAfter);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = d;
        @(negedge clk);
        checkOutput("discard_no_wb_valid", 64'(mem_to_wb_valid), 64'(0));
        step();
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        checkOutput("discard_busy_after_drop", 64'(discard_busy), 64'(expBusyAfter));
        step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && mem_to_wb_valid && wb_allowin) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_wb: got pc=%h wdata=%h, expected no transfer", wb_pc, wb_rf_wdata);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wb_pc", 64'(wb_pc), 64'(e.pc));
                    checkOutput("wb_rf_wdata", 64'(wb_rf_wdata), 64'(e.wdata));
                    checkOutput("wb_excep", 64'(wb_excep), 64'(e.excep));
                    checkOutput("wb_meta_low", wb_meta[63:0], {e.pc, e.pc});
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        reset = 1'b1;
        ex_valid = 1'b0; ex_pc = '0; ex_rf_we = 1'b0; ex_rf_waddr = '0; ex_alu_result = '0;
        ex_ld = 1'b0; ex_req = 1'b0; ex_ld_size = LD_W; ex_ld_unsigned = 1'b0;
        ex_excep = 1'b0; ex_ertn = 1'b0; ex_meta = '0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0; flush = 1'b0; wb_allowin = 1'b1;
        step(); step();
        @(negedge clk);
        checkOutput("rst_wb_valid", 64'(mem_to_wb_valid), 64'(0));
        checkOutput("rst_allowin", 64'(mem_allowin), 64'(1));
        checkOutput("rst_fwd_valid", 64'(fwd_valid), 64'(0));
        checkOutput("rst_discard_busy", 64'(discard_busy), 64'(0));
        reset = 1'b0;
        step();

        // Word load answered as soon as it sits in MEM: bypass to WB.
        applyStimulus(32'h100, 32'h1000, 1'b1, 1'b1, LD_W, 1'b0, 1'b0, 1'b1, 32'h800000F0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h800000F0;
        @(negedge clk);
        checkOutput("bypass_wb_valid", 64'(mem_to_wb_valid), 64'(1));
        step();
        data_sram_data_ok = 1'b0;

        // Extension cases on rdata 0x80FF0000.
        applyStimulus(32'h110, 32'h2003, 1'b1, 1'b1, LD_B, 1'b0, 1'b0, 1'b1, 32'hFFFFFF80);
        respond(32'h80FF0000);
        applyStimulus(32'h114, 32'h2003, 1'b1, 1'b1, LD_B, 1'b1, 1'b0, 1'b1, 32'h00000080);
        respond(32'h80FF0000);
        applyStimulus(32'h118, 32'h2002, 1'b1, 1'b1, LD_H, 1'b0, 1'b0, 1'b1, 32'hFFFF80FF);
        respond(32'h80FF0000);
        applyStimulus(32'h11C, 32'h2000, 1'b1, 1'b1, LD_H, 1'b0, 1'b0, 1'b1, 32'h00000000);
        respond(32'h80FF0000);

        // Backpressure with a full FIFO.
        wb_allowin = 1'b0;
        applyStimulus(32'h200, 32'h3000, 1'b1, 1'b1, LD_W, 1'b0, 1'b0, 1'b1, 32'h11);
        applyStimulus(32'h204, 32'h3004, 1'b1, 1'b1, LD_W, 1'b0, 1'b0, 1'b1, 32'h22);
        setEx(32'h208, 32'h3008, 1'b1, 1'b1, LD_W, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp_allowin_full", 64'(mem_allowin), 64'(0));
        step();
        respond(32'h11);
        respond(32'h22);
        @(negedge clk);
        checkOutput("bp_fwd_ready", 64'(fwd_ready), 64'(2'b11));
        checkOutput("bp_fwd_wdata", 64'(fwd_wdata), {32'h22, 32'h11});
        checkOutput("bp_allowin_still0", 64'(mem_allowin), 64'(0));
        step();
        pushExp(32'h208, 32'h33, 1'b0);
        wb_allowin = 1'b1;
        @(negedge clk);
        checkOutput("bp_allowin_on_drain", 64'(mem_allowin), 64'(1));
        step();
        ex_valid = 1'b0;
        step();
        respond(32'h33);

        // Flush with two unanswered requests plus one issuing in EX.
        applyStimulus(32'h300, 32'h4000, 1'b1, 1'b1, LD_W, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(32'h304, 32'h4004, 1'b1, 1'b1, LD_W, 1'b0, 1'b0, 1'b0, 32'h0);
        setEx(32'h308, 32'h4008, 1'b1, 1'b1, LD_W, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        ex_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_discard_busy", 64'(discard_busy), 64'(1));
        checkOutput("flush_fwd_valid", 64'(fwd_valid), 64'(0));
        step();
        applyStimulus(32'h400, 32'h5000, 1'b1, 1'b1, LD_W, 1'b0, 1'b0, 1'b1, 32'h44);
        respondDropped(32'hAA, 1'b1);
        respondDropped(32'hBB, 1'b1);
        respondDropped(32'hCC, 1'b0);
        respond(32'h44);

        // Head leaves, new entry enters and entry 1 is answered in one cycle.
        wb_allowin = 1'b0;
        applyStimulus(32'h500, 32'h6000, 1'b1, 1'b1, LD_W, 1'b0, 1'b0, 1'b1, 32'h55);
        applyStimulus(32'h504, 32'h6004, 1'b1, 1'b1, LD_W, 1'b0, 1'b0, 1'b1, 32'h66);
        respond(32'h55);
        setEx(32'h508, 32'h6008, 1'b1, 1'b1, LD_W, 1'b0, 1'b0);
        pushExp(32'h508, 32'h77, 1'b0);
        wb_allowin = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h66;
        @(negedge clk);
        checkOutput("sim_allowin", 64'(mem_allowin), 64'(1));
        step();
        ex_valid = 1'b0;
        data_sram_data_ok = 1'b0;
        wb_allowin = 1'b0;
        @(negedge clk);
        checkOutput("sim_still_full", 64'(mem_allowin), 64'(0));
        checkOutput("sim_fwd_valid", 64'(fwd_valid), 64'(2'b11));
        checkOutput("sim_fwd_ready", 64'(fwd_ready), 64'(2'b01));
        checkOutput("sim_fwd_wdata0", 64'(fwd_wdata[31:0]), 64'(32'h66));
        step();
        wb_allowin = 1'b1;
        step();
        respond(32'h77);

        // Exception entry holds mem_excep_pending until it leaves.
        wb_allowin = 1'b0;
        applyStimulus(32'h600, 32'h1234, 1'b0, 1'b0, LD_W, 1'b0, 1'b1, 1'b1, 32'h1234);
        @(negedge clk);
        checkOutput("excep_pending_set", 64'(mem_excep_pending), 64'(1));
        step();
        @(negedge clk);
        checkOutput("excep_pending_hold", 64'(mem_excep_pending), 64'(1));
        step();
        wb_allowin = 1'b1;
        step();
        @(negedge clk);
        checkOutput("excep_pending_clear", 64'(mem_excep_pending), 64'(0));
        step();

        // Reset in the middle of work: discard pending and two entries queued.
        wb_allowin = 1'b0;
        applyStimulus(32'h680, 32'h7000, 1'b1, 1'b1, LD_W, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(32'h684, 32'h7004, 1'b1, 1'b1, LD_W, 1'b0, 1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        applyStimulus(32'h688, 32'h7008, 1'b1, 1'b1, LD_W, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(32'h68C, 32'h700C, 1'b1, 1'b1, LD_W, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("pre_rst_fwd_valid", 64'(fwd_valid), 64'(2'b11));
        checkOutput("pre_rst_discard", 64'(discard_busy), 64'(1));
        reset = 1'b1;
        step();
        @(negedge clk);
        checkOutput("mid_rst_wb_valid", 64'(mem_to_wb_valid), 64'(0));
        checkOutput("mid_rst_fwd_valid", 64'(fwd_valid), 64'(0));
        checkOutput("mid_rst_excep", 64'(mem_excep_pending), 64'(0));
        checkOutput("mid_rst_discard", 64'(discard_busy), 64'(0));
        checkOutput("mid_rst_allowin", 64'(mem_allowin), 64'(1));
        checkOutput("mid_rst_wdata", 64'(wb_rf_wdata), 64'(0));
        checkOutput("mid_rst_fwd_wdata", 64'(fwd_wdata), 64'(0));
        reset = 1'b0;
        wb_allowin = 1'b1;
        step();
        applyStimulus(32'h700, 32'h8000, 1'b1, 1'b1, LD_W, 1'b0, 1'b0, 1'b1, 32'h99);
        respond(32'h99);

        for (int i = 0; i < 20 && expQ.size() != 0; i++) step();
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
